regfile_bist: RTL

Built-in self-test initiator for the 32×64 register file (`regfile`: two combinational read ports, one posedge write port, X31 hard-wired to zero). On `start` it drives the register file's write and read ports through a fixed sequence. The sequence attempts an illegal write to X31, writes a pattern to X0–X30, reads every register back on both ports, and checks that `RegWrite=0` blocks writes. It then reports pass/fail, a mismatch count and the first failing register. It sits beside `regfile` and takes over its ports during test; the port muxing is outside this block.

---
 rtl/regfile_bist.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_bist.sv
// -----------------------------------------------------------------------------
// regfile_bist
//
// Built-in self-test initiator for a 32 x 64-bit register file. The register
// file has two combinational read ports and one posedge write port, and X31 is
// hard-wired to zero. When started, this block drives the register file ports
// through a fixed sequence:
//   1. an illegal write of 0xA0 to X31;
//   2. a pattern write to X0..X30 (register i receives i*PATTERN);
//   3. a read-back of every register on both ports, with port 2 one address
//      behind port 1;
//   4. a write with RegWrite=0 to HOLD_REG, followed by a read-back of HOLD_REG.
// It then reports pass/fail, a saturating mismatch count and the address of
// the first failing read. The muxing that hands the register file ports to
// this block is done elsewhere.
//
// Ports
//   clk            : rising-edge clock shared with the register file
//   reset_n        : asynchronous active-low reset
//   start          : begin a test; only sampled in IDLE or DONE
//   ReadData1/2    : register file read data, ports 1 and 2
//   ReadRegister1/2: register file read addresses, ports 1 and 2
//   WriteRegister  : register file write address
//   WriteData      : register file write data
//   RegWrite       : register file write enable
//   busy           : test in progress
//   done           : test finished, results valid
//   pass           : done with zero mismatches
//   err_count      : mismatch count, saturating at 127
//   first_fail_reg : address of the first mismatching read, 0 if none
// -----------------------------------------------------------------------------
module regfile_bist #(
    parameter logic [63:0] PATTERN   = 64'h0000010204080001,
    parameter logic [4:0]  HOLD_REG  = 5'd10,
    parameter logic [63:0] HOLD_DATA = 64'hAAAAAAAAAAAAAAAA
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [63:0] ReadData1,
    input  logic [63:0] ReadData2,
    output logic [4:0]  ReadRegister1,
    output logic [4:0]  ReadRegister2,
    output logic [4:0]  WriteRegister,
    output logic [63:0] WriteData,
    output logic        RegWrite,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [6:0]  err_count,
    output logic [4:0]  first_fail_reg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W31    = 3'd1,
        S_WRITE  = 3'd2,
        S_READ   = 3'd3,
        S_HOLD_W = 3'd4,
        S_HOLD_R = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [4:0]  LAST_WRITE_IDX = 5'd30;
    localparam logic [4:0]  LAST_READ_IDX  = 5'd31;
    localparam logic [63:0] W31_DATA       = 64'h00000000000000A0;
    localparam logic [6:0]  ERR_MAX        = 7'd127;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [4:0]  r_idx;
    logic [6:0]  r_err_count;
    logic [4:0]  r_first_fail;
    logic        r_fail_seen;

    // -------------------------------------------------------------------------
    // Golden contents table: entry r holds what register r must read back as.
    // X31 always reads zero on a healthy register file. All entries are
    // constants, so this reduces to a 32:1 constant mux per lookup.
    // -------------------------------------------------------------------------
    logic [63:0] w_golden [32];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_golden
            if (gi == 31) begin : g_zero
                assign w_golden[gi] = '0;
            end else begin : g_mult
                assign w_golden[gi] = PATTERN * 64'(gi);
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Register-file-facing outputs decoded purely from r_state / r_idx, so no
    // combinational path exists from any input to these outputs.
    // -------------------------------------------------------------------------
    logic [4:0] w_idx_prev;
    assign w_idx_prev = r_idx - 5'd1;   // wraps 0 -> 31 for the port 2 lag

    always_comb begin
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        WriteRegister = '0;
        WriteData     = '0;
        RegWrite      = 1'b0;
        unique case (r_state)
            S_W31: begin
                WriteRegister = 5'd31;
                WriteData     = W31_DATA;
                RegWrite      = 1'b1;
            end
            S_WRITE: begin
                WriteRegister = r_idx;
                WriteData     = w_golden[r_idx];
                RegWrite      = 1'b1;
            end
            S_READ: begin
                ReadRegister1 = r_idx;
                ReadRegister2 = w_idx_prev;
            end
            S_HOLD_W: begin
                // Address and data are presented with the enable low; a
                // healthy register file must not commit this.
                WriteRegister = HOLD_REG;
                WriteData     = HOLD_DATA;
            end
            S_HOLD_R: begin
                ReadRegister1 = HOLD_REG;
            end
            default: begin
            end
        endcase
    end

    assign busy           = (r_state == S_W31)    || (r_state == S_WRITE)  ||
                            (r_state == S_READ)   || (r_state == S_HOLD_W) ||
                            (r_state == S_HOLD_R);
    assign done           = (r_state == S_DONE);
    assign pass           = done && (r_err_count == 7'd0);
    assign err_count      = r_err_count;
    assign first_fail_reg = r_first_fail;

    // -------------------------------------------------------------------------
    // Read-back comparison. HOLD_R checks port 1 only.
    // -------------------------------------------------------------------------
    logic        w_cmp1_en;
    logic        w_cmp2_en;
    logic [63:0] w_exp1;
    logic [63:0] w_exp2;
    logic        w_mis1;
    logic        w_mis2;
    logic [1:0]  w_mis_cnt;
    logic [7:0]  w_err_sum;
    logic [6:0]  w_err_sat;

    assign w_cmp1_en = (r_state == S_READ) || (r_state == S_HOLD_R);
    assign w_cmp2_en = (r_state == S_READ);
    assign w_exp1    = w_golden[ReadRegister1];
    assign w_exp2    = w_golden[ReadRegister2];
    assign w_mis1    = w_cmp1_en && (ReadData1 != w_exp1);
    assign w_mis2    = w_cmp2_en && (ReadData2 != w_exp2);
    assign w_mis_cnt = {1'b0, w_mis1} + {1'b0, w_mis2};
    assign w_err_sum = {1'b0, r_err_count} + {6'd0, w_mis_cnt};
    assign w_err_sat = (w_err_sum > {1'b0, ERR_MAX}) ? ERR_MAX : w_err_sum[6:0];

    // -------------------------------------------------------------------------
    // Sequencer and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_err_count  <= '0;
            r_first_fail <= '0;
            r_fail_seen  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_W31;
                        r_idx        <= '0;
                        r_err_count  <= '0;
                        r_first_fail <= '0;
                        r_fail_seen  <= 1'b0;
                    end
                end
                S_W31: begin
                    r_state <= S_WRITE;
                    r_idx   <= '0;
                end
                S_WRITE: begin
                    if (r_idx == LAST_WRITE_IDX) begin
                        r_state <= S_READ;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                S_READ: begin
                    if (r_idx == LAST_READ_IDX) begin
                        r_state <= S_HOLD_W;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                S_HOLD_W: begin
                    r_state <= S_HOLD_R;
                end
                S_HOLD_R: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                end
            endcase

            // Compare results commit at the edge that closes the READ/HOLD_R
            // cycle. Comparison is never enabled in IDLE/DONE, so this never
            // collides with the clear on start above.
            if (w_mis1 || w_mis2) begin
                r_err_count <= w_err_sat;
                if (!r_fail_seen) begin
                    r_fail_seen  <= 1'b1;
                    // Port 1 takes priority when both ports miss together.
                    r_first_fail <= w_mis1 ? ReadRegister1 : ReadRegister2;
                end
            end
        end
    end

endmodule
